// File: rtl/vp_fmul_pipe_if.sv
// Operand/result handshake bundle for vp_fmul_pipe.
// master drives operands and accepts results; slave is the multiplier.
interface vp_fmul_pipe_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [10:0]      out_mask;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_mask
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_mask
  );
endinterface

// File: rtl/vp_fmul_pipe.sv
// 3-stage FP32 multiplier whose operand precision is set by the product's exponent magnitude.
// Stages: unpack/mask, 12x12 multiply, normalise/pack. Whole pipe stalls together.
module vp_fmul_pipe #(
  parameter int unsigned TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  vp_fmul_pipe_if.slave   bus
);

  typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} special_e;

  logic adv;

  // S1 signals
  logic [7:0]        ea, eb;
  logic signed [9:0] p, p_abs;
  logic [3:0]        r, bw;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [10:0]       s1_mask_d;
  logic [11:0]       s1_sa_d, s1_sb_d;
  logic signed [9:0] s1_e_d;
  logic              s1_sign_d;
  special_e          s1_sp_d;

  logic              s1_valid_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [10:0]       s1_mask_q;
  logic [11:0]       s1_sa_q, s1_sb_q;
  logic signed [9:0] s1_e_q;
  logic              s1_sign_q;
  special_e          s1_sp_q;

  // S2 signals
  logic [23:0]       s2_prod_d;
  logic              s2_valid_q;
  logic [TAG_W-1:0]  s2_tag_q;
  logic [10:0]       s2_mask_q;
  logic [23:0]       s2_prod_q;
  logic signed [9:0] s2_e_q;
  logic              s2_sign_q;
  special_e          s2_sp_q;

  // S3 signals
  logic signed [9:0] e_n;
  logic [10:0]       frac_n;
  logic [31:0]       out_data_d;
  logic              out_valid_q;
  logic [31:0]       out_data_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [10:0]       out_mask_q;

  assign adv           = bus.out_ready | ~out_valid_q;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_mask  = out_mask_q;

  always_comb begin
    ea    = bus.in_a[30:23];
    eb    = bus.in_b[30:23];
    p     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd254;
    p_abs = p[9] ? -p : p;
    r     = p_abs[7:4];
    // Small and very large unbiased exponents keep full precision; mid range drops to 4 bits
    bw    = (r <= 4'd7) ? (4'd11 - r) : (r - 4'd4);
    s1_mask_d = ~(11'h7ff >> bw);
    s1_sa_d   = {1'b1, bus.in_a[22:12] & s1_mask_d};
    s1_sb_d   = {1'b1, bus.in_b[22:12] & s1_mask_d};
    s1_e_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    s1_sign_d = bus.in_a[31] ^ bus.in_b[31];

    a_zero = ~|ea;
    b_zero = ~|eb;
    a_nan  = (&ea) & (|bus.in_a[22:0]);
    b_nan  = (&eb) & (|bus.in_b[22:0]);
    a_inf  = (&ea) & ~(|bus.in_a[22:0]);
    b_inf  = (&eb) & ~(|bus.in_b[22:0]);

    s1_sp_d = SpNone;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s1_sp_d = SpNan;
    end else if (a_inf || b_inf) begin
      s1_sp_d = SpInf;
    end else if (a_zero || b_zero) begin
      s1_sp_d = SpZero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_mask_q  <= '0;
      s1_sa_q    <= '0;
      s1_sb_q    <= '0;
      s1_e_q     <= '0;
      s1_sign_q  <= 1'b0;
      s1_sp_q    <= SpNone;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_tag_q   <= bus.in_tag;
      s1_mask_q  <= s1_mask_d;
      s1_sa_q    <= s1_sa_d;
      s1_sb_q    <= s1_sb_d;
      s1_e_q     <= s1_e_d;
      s1_sign_q  <= s1_sign_d;
      s1_sp_q    <= s1_sp_d;
    end
  end

  assign s2_prod_d = s1_sa_q * s1_sb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_mask_q  <= '0;
      s2_prod_q  <= '0;
      s2_e_q     <= '0;
      s2_sign_q  <= 1'b0;
      s2_sp_q    <= SpNone;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
      s2_mask_q  <= s1_mask_q;
      s2_prod_q  <= s2_prod_d;
      s2_e_q     <= s1_e_q;
      s2_sign_q  <= s1_sign_q;
      s2_sp_q    <= s1_sp_q;
    end
  end

  always_comb begin
    e_n    = s2_prod_q[23] ? (s2_e_q + 10'sd1) : s2_e_q;
    frac_n = s2_prod_q[23] ? s2_prod_q[22:12] : s2_prod_q[21:11];
    out_data_d = {s2_sign_q, e_n[7:0], frac_n, 12'b0};
    unique case (s2_sp_q)
      SpNan:  out_data_d = 32'h7fc0_0000;
      SpInf:  out_data_d = {s2_sign_q, 8'hff, 23'b0};
      SpZero: out_data_d = {s2_sign_q, 31'b0};
      default: begin
        if (e_n >= 10'sd255) begin
          out_data_d = {s2_sign_q, 8'hff, 23'b0};
        end else if (e_n <= 10'sd0) begin
          out_data_d = {s2_sign_q, 31'b0};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_mask_q  <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      out_data_q  <= out_data_d;
      out_tag_q   <= s2_tag_q;
      out_mask_q  <= s2_mask_q;
    end
  end

endmodule

// File: tb/tb_vp_fmul_pipe.sv
// Bench for vp_fmul_pipe: directed vectors, stall, reset flush and random traffic
// scored against an integer model of the variable-precision multiply.
module tb_vp_fmul_pipe;

  logic clk;
  logic rst;

  vp_fmul_pipe_if #(.TAG_W(4)) bus ();

  vp_fmul_pipe #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [10:0] mask;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int emitted = 0;

  logic [31:0] da [8] = '{32'h3f800000, 32'h3fffffff, 32'h7f000000, 32'h00800000,
                          32'h80000000, 32'h7f800000, 32'hff800000, 32'h7fc00001};
  logic [31:0] db [8] = '{32'h3f800000, 32'h53800000, 32'h7f000000, 32'h00800000,
                          32'h3f800000, 32'h00000000, 32'h40000000, 32'h3f800000};
  logic [31:0] dx [8] = '{32'h3f800000, 32'h53ffc000, 32'h7f800000, 32'h00000000,
                          32'h80000000, 32'h7fc00000, 32'hff800000, 32'h7fc00000};
  logic [10:0] dm [8] = '{11'h7ff, 11'h7fc, 11'h7ff, 11'h7ff,
                          11'h780, 11'h7ff, 11'h780, 11'h780};

  // Reference: exponent-driven bit budget, 12x12 integer product, truncate, specials first
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic [10:0] m);
    int ea, eb, p, r, bw, e, fa, fb, prod, frac;
    bit sgn, a_inf, b_inf, a_nan, b_nan;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    p = ea + eb - 254;
    if (p < 0) p = -p;
    r = (p / 16) % 16;
    bw = (r <= 7) ? 11 - r : r - 4;
    m = 11'(((1 << bw) - 1) << (11 - bw));
    fa = int'(a[22:12]) & int'(m);
    fb = int'(b[22:12]) & int'(m);
    prod = (2048 + fa) * (2048 + fb);
    e = ea + eb - 127;
    if (prod >= (1 << 23)) begin
      frac = (prod / 4096) % 2048;
      e = e + 1;
    end else begin
      frac = (prod / 2048) % 2048;
    end
    sgn = a[31] ^ b[31];
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0)) d = 32'h7fc00000;
    else if (a_inf || b_inf) d = {sgn, 8'hff, 23'b0};
    else if (ea == 0 || eb == 0) d = {sgn, 31'b0};
    else if (e >= 255) d = {sgn, 8'hff, 23'b0};
    else if (e <= 0) d = {sgn, 31'b0};
    else d = {sgn, 8'(e), 11'(frac), 12'b0};
  endfunction

  function automatic logic [31:0] rand_fp();
    int k;
    logic [7:0] ex;
    logic [31:0] fr;
    k = int'($urandom_range(0, 15));
    fr = $urandom;
    if (k == 0) ex = 8'h00;
    else if (k == 1) ex = 8'hff;
    else if (k < 4) ex = 8'($urandom_range(0, 255));
    else ex = 8'($urandom_range(90, 164));
    if (k == 1 && $urandom_range(0, 1) == 1) fr = 32'h0;
    return {1'($urandom_range(0, 1)), ex, fr[22:0]};
  endfunction

  // One clock: drive at negedge, observe 1ns later, score transfers, then the edge is taken
  task automatic cycle(input bit r, input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input bit ordy, input bit dir,
                       input logic [31:0] xd, input logic [10:0] xm, input bit lat,
                       output bit acc);
    exp_t e;
    logic [31:0] md;
    logic [10:0] mm;
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_tag = t;
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!r) begin
      if (bus.out_valid && bus.out_ready) begin
        emitted++;
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out: got data=%h tag=%0d, expected no result", bus.out_data,
                 bus.out_tag);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          total++;
          assert (bus.out_data === e.data) else begin
            bad++;
            $error("FAIL out_data tag=%0d: got %h expected %h", e.tag, bus.out_data, e.data);
          end
          total++;
          assert (bus.out_tag === e.tag) else begin
            bad++;
            $error("FAIL out_tag: got %0d expected %0d", bus.out_tag, e.tag);
          end
          total++;
          assert (bus.out_mask === e.mask) else begin
            bad++;
            $error("FAIL out_mask tag=%0d: got %h expected %h", e.tag, bus.out_mask, e.mask);
          end
          if (e.lat) begin
            total++;
            assert (cyc - e.cyc === 3) else begin
              bad++;
              $error("FAIL latency: got %0d expected 3", cyc - e.cyc);
            end
          end
        end
      end
      if (v && bus.in_ready) begin
        acc = 1'b1;
        if (dir) begin
          md = xd;
          mm = xm;
        end else begin
          model(a, b, md, mm);
        end
        e.data = md;
        e.tag = t;
        e.mask = mm;
        e.cyc = cyc;
        e.lat = lat;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ordy, 1'b0, 32'h0, 11'h0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
    total++;
    assert (q.size() === 0) else begin
      bad++;
      $error("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    bit acc;
    int i, c, em0;
    logic [31:0] na, nb;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;

    // Reset state
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 11'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 11'h0, 1'b0, acc);
    idle(1'b1);
    total++;
    assert (bus.out_valid === 1'b0) else begin
      bad++; $error("FAIL rst_valid: got %b expected 0", bus.out_valid);
    end
    total++;
    assert ({bus.out_data, bus.out_tag, bus.out_mask} === 47'h0) else begin
      bad++; $error("FAIL rst_outputs: got %h/%h/%h expected 0", bus.out_data, bus.out_tag,
                    bus.out_mask);
    end
    total++;
    assert (bus.in_ready === 1'b1) else begin
      bad++; $error("FAIL rst_ready: got %b expected 1", bus.in_ready);
    end

    // Directed vectors: first alone with latency check, the rest back-to-back
    cycle(1'b0, 1'b1, da[0], db[0], 4'd0, 1'b1, 1'b1, dx[0], dm[0], 1'b1, acc);
    for (int k = 0; k < 4; k++) idle(1'b1);
    for (int k = 1; k < 8; k++)
      cycle(1'b0, 1'b1, da[k], db[k], 4'(k), 1'b1, 1'b1, dx[k], dm[k], 1'b0, acc);
    drain();

    // Back-to-back 8 ops with a 3-cycle downstream stall mid-stream
    em0 = emitted;
    i = 0;
    c = 0;
    na = rand_fp();
    nb = rand_fp();
    while (i < 8 && c < 60) begin
      bit ordy;
      ordy = !(c >= 5 && c <= 7);
      cycle(1'b0, 1'b1, na, nb, 4'(i), ordy, 1'b0, 32'h0, 11'h0, 1'b0, acc);
      if (!ordy) begin
        total++;
        assert (bus.in_ready === 1'b0) else begin
          bad++; $error("FAIL stall_ready: got %b expected 0", bus.in_ready);
        end
        total++;
        assert (bus.out_valid === 1'b1) else begin
          bad++; $error("FAIL stall_valid: got %b expected 1", bus.out_valid);
        end
        if (q.size() != 0) begin
          total++;
          assert (bus.out_data === q[0].data && bus.out_tag === q[0].tag) else begin
            bad++; $error("FAIL stall_hold: got %h/%0d expected %h/%0d", bus.out_data,
                          bus.out_tag, q[0].data, q[0].tag);
          end
        end
      end
      if (acc) begin
        i++;
        na = rand_fp();
        nb = rand_fp();
      end
      c++;
    end
    drain();
    total++;
    assert (emitted - em0 === 8) else begin
      bad++; $error("FAIL b2b_count: got %0d expected 8", emitted - em0);
    end

    // Random traffic with random bubbles and backpressure
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, $urandom_range(0, 3) != 0, rand_fp(), rand_fp(), 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, 1'b0, 32'h0, 11'h0, 1'b0, acc);
    end
    drain();

    // Reset with three ops in flight: none may emerge afterwards
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, rand_fp(), rand_fp(), 4'(k), 1'b0, 1'b0, 32'h0, 11'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 11'h0, 1'b0, acc);
    q.delete();
    for (int k = 0; k < 6; k++) begin
      idle(1'b1);
      total++;
      assert (bus.out_valid === 1'b0) else begin
        bad++; $error("FAIL flush_valid: got %b expected 0", bus.out_valid);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
